// File: rtl/store_narrow.sv
// rtl/store_narrow.sv - store narrowing unit: 32-bit sb/sh/sw request to 16-bit write beats
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready          store request handshake (ready only in IDLE)
//   req_addr/req_wdata/req_size  byte address, rt value, size (00 b, 01 h, 10 w, 11 illegal)
//   mem_valid/mem_ready          write-beat handshake toward data memory
//   mem_addr/mem_wdata/mem_be    beat address (bit 0 always 0), beat data, byte enables
//   done                         one-cycle pulse after the final beat completes
//   misalign_err                 one-cycle pulse after a rejected request
//   busy                         unit not IDLE (pipeline stall)
module store_narrow #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_be,
    output logic              done,
    output logic              misalign_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic [1:0]        cap_size;
    logic              accept;
    logic              bad;
    logic              last_beat_done;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    assign bad = (req_size == 2'b11)
              || (req_size == SZ_HALF && req_addr[0])
              || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

    // Final beat: BEAT1 always, or BEAT0 of anything that is not a word.
    assign last_beat_done = mem_ready
        && ((state == BEAT1) || (state == BEAT0 && cap_size != SZ_WORD));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !bad) begin
                    state_next = BEAT0;
                end
            end
            BEAT0: begin
                if (mem_ready) begin
                    state_next = (cap_size == SZ_WORD) ? BEAT1 : IDLE;
                end
            end
            BEAT1: begin
                if (mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_size     <= '0;
            done         <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            if (accept && !bad) begin
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_size  <= req_size;
            end
            done         <= last_beat_done;
            misalign_err <= accept && bad;
        end
    end

    // Beat outputs decoded only from state and captured registers, so they hold during stalls.
    always_comb begin
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 2'b00;
        case (state)
            BEAT0: begin
                mem_valid = 1'b1;
                if (cap_size == SZ_BYTE) begin
                    mem_addr  = {cap_addr[ADDR_W-1:1], 1'b0};
                    mem_wdata = {cap_wdata[7:0], cap_wdata[7:0]};
                    mem_be    = cap_addr[0] ? 2'b10 : 2'b01;
                end else begin
                    mem_addr  = cap_addr;
                    mem_wdata = cap_wdata[15:0];
                    mem_be    = 2'b11;
                end
            end
            BEAT1: begin
                mem_valid = 1'b1;
                mem_addr  = cap_addr + ADDR_W'(2);
                mem_wdata = cap_wdata[31:16];
                mem_be    = 2'b11;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_store_narrow.sv
// tb/tb_store_narrow.sv - self-checking bench for store_narrow
module tb_store_narrow;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        done;
    logic        misalign_err;
    logic        busy;

    always #5 clk = ~clk;

    store_narrow #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .done         (done),
        .misalign_err (misalign_err),
        .busy         (busy)
    );

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } beat_t;

    beat_t q[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: returns 1 if the request must be rejected, otherwise queues its beats.
    function automatic bit model(input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        beat_t b;
        case (size)
            2'b00: begin
                b.addr = addr & 32'hFFFF_FFFE;
                b.data = {wdata[7:0], wdata[7:0]};
                b.be   = addr[0] ? 2'b10 : 2'b01;
                q.push_back(b);
                return 1'b0;
            end
            2'b01: begin
                if (addr[0]) return 1'b1;
                b.addr = addr; b.data = wdata[15:0]; b.be = 2'b11;
                q.push_back(b);
                return 1'b0;
            end
            2'b10: begin
                if (addr[1:0] != 2'b00) return 1'b1;
                b.addr = addr; b.data = wdata[15:0]; b.be = 2'b11;
                q.push_back(b);
                b.addr = addr + 32'd2; b.data = wdata[31:16];
                q.push_back(b);
                return 1'b0;
            end
            default: return 1'b1;
        endcase
    endfunction

    // Compare the presented beat with the scoreboard head; pop when it completes.
    task automatic check_beat(input string tag);
        beat_t e;
        chk({tag, " mem_valid"}, {31'd0, mem_valid}, 32'd1);
        if (q.size() == 0) begin
            chk({tag, " unexpected beat"}, 32'd1, 32'd0);
            return;
        end
        e = q[0];
        chk({tag, " mem_addr"}, mem_addr, e.addr);
        chk({tag, " mem_wdata"}, {16'd0, mem_wdata}, {16'd0, e.data});
        chk({tag, " mem_be"}, {30'd0, mem_be}, {30'd0, e.be});
        if (mem_ready) void'(q.pop_front());
    endtask

    task automatic do_req(input vec_t v);
        bit is_err;
        int stall_left;
        int cnt;
        is_err = model(v.size, v.addr, v.wdata);
        @(negedge clk);
        chk("req_ready before accept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_size  = v.size;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_0000;
        req_wdata = 32'h0;
        if (is_err) begin
            chk("err pulse", {31'd0, misalign_err}, 32'd1);
            chk("err no mem_valid", {31'd0, mem_valid}, 32'd0);
            chk("err req_ready", {31'd0, req_ready}, 32'd1);
            chk("err no done", {31'd0, done}, 32'd0);
            @(posedge clk);
            #1;
            chk("err pulse end", {31'd0, misalign_err}, 32'd0);
            chk("err still no mem_valid", {31'd0, mem_valid}, 32'd0);
            return;
        end
        stall_left = v.stall;
        cnt = 0;
        while (q.size() > 0 && cnt < 30) begin
            if (stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
            end else begin
                mem_ready = 1'b1;
            end
            chk("busy during store", {31'd0, busy}, 32'd1);
            chk("no done mid store", {31'd0, done}, 32'd0);
            check_beat("beat");
            @(posedge clk);
            #1;
            cnt++;
        end
        if (q.size() != 0) begin
            chk("beat timeout", q.size(), 32'd0);
            q.delete();
        end
        mem_ready = 1'b1;
        chk("done pulse", {31'd0, done}, 32'd1);
        chk("idle after store", {31'd0, busy}, 32'd0);
        chk("ready in done cycle", {31'd0, req_ready}, 32'd1);
        chk("no err with done", {31'd0, misalign_err}, 32'd0);
        @(posedge clk);
        #1;
        chk("done one cycle", {31'd0, done}, 32'd0);
        chk("mem_valid idle", {31'd0, mem_valid}, 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{2'b00, 32'h0000_1003, 32'hAABB_CCDD, 0});
        vecs.push_back('{2'b00, 32'h0000_1000, 32'h0000_0042, 0});
        vecs.push_back('{2'b01, 32'h0000_2002, 32'h1234_5678, 0});
        vecs.push_back('{2'b10, 32'h0000_3000, 32'hDEAD_BEEF, 3});
        vecs.push_back('{2'b01, 32'h0000_0001, 32'h1111_2222, 0});
        vecs.push_back('{2'b10, 32'h0000_0006, 32'h3333_4444, 0});
        vecs.push_back('{2'b11, 32'h0000_0008, 32'h5555_6666, 0});
        vecs.push_back('{2'b01, 32'h0000_4000, 32'hCAFE_F00D, 2});
        vecs.push_back('{2'b10, 32'h0000_5004, 32'h0102_0304, 1});

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_size  = '0;
        mem_ready = 1'b1;
        #12;
        chk("rst mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst mem_be", {30'd0, mem_be}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst misalign_err", {31'd0, misalign_err}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) do_req(vecs[i]);

        // Word at the top of memory, with a second word queued and accepted in the done cycle.
        @(negedge clk);
        void'(model(2'b10, 32'hFFFF_FFFC, 32'hA1B2_C3D4));
        void'(model(2'b10, 32'h0000_0010, 32'h5566_7788));
        mem_ready = 1'b1;
        req_valid = 1'b1; req_size = 2'b10; req_addr = 32'hFFFF_FFFC; req_wdata = 32'hA1B2_C3D4;
        @(posedge clk);
        #1;
        req_addr = 32'h0000_0010; req_wdata = 32'h5566_7788;
        check_beat("wrap b0");
        @(posedge clk);
        #1;
        check_beat("wrap b1");
        @(posedge clk);
        #1;
        chk("wrap done", {31'd0, done}, 32'd1);
        chk("wrap ready in done", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("b2b done cleared", {31'd0, done}, 32'd0);
        check_beat("b2b b0");
        @(posedge clk);
        #1;
        check_beat("b2b b1");
        @(posedge clk);
        #1;
        chk("b2b done", {31'd0, done}, 32'd1);
        chk("b2b queue empty", q.size(), 32'd0);
        q.delete();

        // Reset during BEAT1 aborts the store.
        @(negedge clk);
        void'(model(2'b10, 32'h0000_6000, 32'h9999_8888));
        req_valid = 1'b1; req_size = 2'b10; req_addr = 32'h0000_6000; req_wdata = 32'h9999_8888;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_beat("abort b0");
        @(posedge clk);
        #1;
        chk("abort in BEAT1", mem_addr, 32'h0000_6002);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort mem_valid drop", {31'd0, mem_valid}, 32'd0);
        chk("abort busy drop", {31'd0, busy}, 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort ready", {31'd0, req_ready}, 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("abort no done", {31'd0, done}, 32'd0);
        end
        do_req('{2'b00, 32'h0000_7001, 32'h0000_00A5, 0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/store_narrow.md
# store_narrow

Memory-stage store narrowing unit for the MIPS pipeline, and the counterpart of the load-path sign/zero extender. It takes a 32-bit store request from the EX/MEM register (byte, halfword or word) and turns it into one or two 16-bit write beats with byte enables on the data-memory bus. While the memory bus is busy it holds the pipeline off via a ready/busy handshake. Misaligned or illegal stores are flagged without touching memory.

## Interface
- ADDR_W, 32, byte-address width of request and memory bus

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  register value to store (rt)
- req_size  in  2  00 byte (sb), 01 half (sh), 10 word (sw), 11 illegal
- mem_valid  out  1  write beat present on memory bus
- mem_ready  in  1  memory accepts beat
- mem_addr  out  ADDR_W  beat address, bit 0 always 0
- mem_wdata  out  16  beat data
- mem_be  out  2  byte enables; bit0 = mem_wdata[7:0], bit1 = mem_wdata[15:8]
- done  out  1  one-cycle pulse: store fully written
- misalign_err  out  1  one-cycle pulse: request rejected
- busy  out  1  state != IDLE (drives the pipeline stall)

## Operation
- States: IDLE, BEAT0, BEAT1. req_ready = (state == IDLE), combinational.
- Accept happens on an edge with req_valid && req_ready. addr, wdata and size are captured into internal registers. Inputs are ignored outside the accept edge.
- Alignment check at accept:
  - size 01 with addr[0]=1: error.
  - size 10 with addr[1:0]!=0: error.
  - size 11: error.
  - On any error: state stays IDLE, misalign_err=1 for the next cycle, no beat is issued, done stays 0.
- Byte: IDLE→BEAT0.
  - mem_addr = {addr[ADDR_W-1:1],1'b0}; mem_wdata = {wdata[7:0],wdata[7:0]}.
  - mem_be = addr[0] ? 2'b10 : 2'b01.
- Half: IDLE→BEAT0. mem_addr = addr; mem_wdata = wdata[15:0]; mem_be = 2'b11.
- Word: IDLE→BEAT0→BEAT1, little-endian.
  - BEAT0: mem_addr = addr, data = wdata[15:0], be = 11.
  - BEAT1: mem_addr = addr+2, data = wdata[31:16], be = 11.
  - addr+2 wraps modulo 2^ADDR_W.
- mem_valid = 1 in BEAT0 and BEAT1. All mem_* outputs are registered or decoded from captured registers only, so they are stable while mem_valid && !mem_ready.
- A beat completes on an edge with mem_valid && mem_ready.
  - Final beat: state→IDLE, done=1 for the next cycle.
  - BEAT0 of a word: state→BEAT1.
- done and misalign_err are never high together.

## Timing
- Reset (rst_n low, async): state=IDLE, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0, misalign_err=0, busy=0, req_ready=1.
- Reset mid-operation aborts the store. mem_valid drops immediately, and no done follows.
- Accept at edge N → mem_valid high from edge N (registered state).
- With mem_ready held 1:
  - Byte/half: beat completes at edge N+1, done high N+1..N+2.
  - Word: beats complete at N+1 and N+2, done high N+2..N+3.
- Each cycle with mem_ready=0 adds one cycle and holds the beat unchanged.
- Back-to-back: in the cycle done is high, state is IDLE and req_ready=1, so a new request may be accepted on that same edge.
- Error path: accept at N → misalign_err high N..N+1 and req_ready stays 1, so the next request may be accepted at N+1.
- mem_ready while mem_valid=0 is ignored.

## Test plan
- sb: addr=0x1003, wdata=0xAABBCCDD, mem_ready=1 → one beat: mem_addr=0x1002, mem_wdata=0xDDDD, mem_be=10; done one cycle after the beat.
- sh: addr=0x2002, wdata=0x12345678 → one beat: mem_addr=0x2002, mem_wdata=0x5678, be=11.
- sw: addr=0x3000, wdata=0xDEADBEEF, mem_ready stalled 3 cycles on BEAT0 → required response:
  - BEAT0 (0x3000, 0xBEEF) held stable through the stall.
  - Then BEAT1 (0x3002, 0xDEAD).
  - done once; busy high throughout.
- Misaligned and illegal requests → misalign_err pulses, no mem_valid, and req_ready stays 1:
  - sh at addr=0x0001.
  - sw at addr=0x0006.
  - size=11.
- Word store at addr=0xFFFFFFFC → BEAT1 address is 0xFFFFFFFE; a second sw queued on req_valid is accepted in the done cycle with no idle gap.
- rst_n low during BEAT1 → mem_valid=0 immediately, no done; after release req_ready=1 and a new sb completes normally.
